ifmp1_slave_rsp: RTL and testbench



---
 rtl/ifmp1_pkg.sv | 19 +
 rtl/ifmp1_slave_rsp_if.sv | 32 +++
 rtl/ifmp1_rsp_fifo.sv | 75 +++++++
 rtl/ifmp1_slave_rsp.sv | 110 +++++++++++
 tb/tb_ifmp1_slave_rsp.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifmp1_pkg.sv
// Shared types for the ifmp1 slave responder: data word type and FSM states.
package ifmp1_pkg;

  localparam int IFMP1_WIDTH = 32;

  typedef logic [IFMP1_WIDTH-1:0] ifmp1_word_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_FLUSH
  } ifmp1_rsp_state_t;

  // Occupancy counters need one bit more than the pointers so full != empty.
  function automatic int ifmp1_level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifmp1_slave_rsp_if.sv
// ifmp1 responder bus: master-side word/valid, slave ready, downstream
// valid/ready port and status. The master modport is the environment side.
interface ifmp1_slave_rsp_if
  import ifmp1_pkg::*;
#(
  parameter int WIDTH = IFMP1_WIDTH,
  parameter int DEPTH = 4
);

  localparam int LW = ifmp1_level_width(DEPTH);

  logic [WIDTH-1:0] sig1;
  logic             sig1_vld;
  logic             sig2;
  logic             flush;
  logic [WIDTH-1:0] out_data;
  logic             out_vld;
  logic             out_rdy;
  logic             busy;
  logic [LW-1:0]    level;

  modport master (
    output sig1, sig1_vld, flush, out_rdy,
    input  sig2, out_data, out_vld, busy, level
  );

  modport slave (
    input  sig1, sig1_vld, flush, out_rdy,
    output sig2, out_data, out_vld, busy, level
  );

endinterface

// File: rtl/ifmp1_rsp_fifo.sv
// DEPTH-entry FIFO with a registered head word. A word written at edge N is
// loaded into the head register at edge N+1. clr wins over push and pop.
module ifmp1_rsp_fifo
  import ifmp1_pkg::*;
#(
  parameter int WIDTH = IFMP1_WIDTH,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = ifmp1_level_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic [LW-1:0]    level,
  output logic [LW-1:0]    level_next
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_adv;
  logic [LW-1:0]    remain;
  logic             do_push;
  logic             do_pop;

  assign do_push    = push & ~clr;
  assign do_pop     = pop & dout_vld & ~clr;
  // Words already stored before this edge that survive the pop; a word being
  // written this edge is not counted, which gives the one-cycle head latency.
  assign remain     = level - LW'(do_pop);
  assign rd_ptr_adv = rd_ptr + AW'(do_pop);

  // Next occupancy, also used by the parent to pre-compute ready.
  always_comb begin
    // NOTE: default first so every path assigns level_next and no latch is inferred.
    level_next = level;
    if (clr) level_next = '0;
    else     level_next = level + LW'(do_push) - LW'(do_pop);
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: validity comes only from pointers and level, so the array has no reset.
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and the registered head word.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      dout_vld <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr   <= rd_ptr_adv;
      level    <= level_next;
      dout_vld <= (remain != '0);
      if (remain != '0) dout <= mem[rd_ptr_adv];
    end
  end

endmodule

// File: rtl/ifmp1_slave_rsp.sv
// ifmp1 slave responder: acknowledges master words with a registered ready
// (sig2), buffers them in a FIFO and presents them on a valid/ready port.
// Optional feature macro: IFMP1_RSP_STATS_EN adds accept_cnt, a wrapping
// count of accepted words since reset (flush does not clear it).
module ifmp1_slave_rsp
  import ifmp1_pkg::*;
#(
  parameter int WIDTH = IFMP1_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  ifmp1_slave_rsp_if.slave  bus
`ifdef IFMP1_RSP_STATS_EN
  ,
  output logic [31:0]       accept_cnt
`endif
);

  localparam int LW = ifmp1_level_width(DEPTH);

  ifmp1_rsp_state_t state;
  logic             sig2_q;
  logic             busy_q;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] out_data_w;
  logic             out_vld_w;
  logic [LW-1:0]    level_w;
  logic [LW-1:0]    level_next;

  // A word offered during a flush cycle is dropped even if ready was high.
  assign push = bus.sig1_vld & sig2_q & ~bus.flush;
  assign pop  = out_vld_w & bus.out_rdy;

  ifmp1_rsp_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .clr        (bus.flush),
    .din        (bus.sig1),
    .dout       (out_data_w),
    .dout_vld   (out_vld_w),
    .level      (level_w),
    .level_next (level_next)
  );

  // FSM with registered ready and busy; ready is low whenever the next state
  // is S_FLUSH, which is exactly the cycles where flush is asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      busy_q <= 1'b0;
      sig2_q <= 1'b0;
    end else begin
      sig2_q <= (level_next < LW'(DEPTH)) && !bus.flush;
      case (state)
        S_IDLE: begin
          if (bus.flush) begin
            state  <= S_FLUSH;
            busy_q <= 1'b0;
          end else if (push) begin
            state  <= S_ACTIVE;
            busy_q <= 1'b1;
          end
        end
        S_ACTIVE: begin
          if (bus.flush) begin
            state  <= S_FLUSH;
            busy_q <= 1'b0;
          end else if (level_next == '0) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        end
        S_FLUSH: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sig2     = sig2_q;
  assign bus.busy     = busy_q;
  assign bus.out_data = out_data_w;
  assign bus.out_vld  = out_vld_w;
  assign bus.level    = level_w;

`ifdef IFMP1_RSP_STATS_EN
  logic [31:0] accept_cnt_q;

  // Accepted-word counter; wraps naturally at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       accept_cnt_q <= '0;
    else if (push) accept_cnt_q <= accept_cnt_q + 32'd1;
  end

  assign accept_cnt = accept_cnt_q;
`endif

endmodule

// File: tb/tb_ifmp1_slave_rsp.sv
// Bench for ifmp1_slave_rsp: reset sequence, a vector table for the
// single-word / fill / push+pop / flush cases, then random traffic against a
// queue-based reference model. Stats checks build with IFMP1_RSP_STATS_EN.
module tb_ifmp1_slave_rsp;
  import ifmp1_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  ifmp1_slave_rsp_if #(.WIDTH(IFMP1_WIDTH), .DEPTH(DEPTH)) bus ();

`ifdef IFMP1_RSP_STATS_EN
  logic [31:0] accept_cnt;
`endif

  ifmp1_slave_rsp #(
    .WIDTH (IFMP1_WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus)
`ifdef IFMP1_RSP_STATS_EN
    ,
    .accept_cnt (accept_cnt)
`endif
  );

  typedef struct {
    logic        vld;
    ifmp1_word_t data;
    logic        rdy;
    logic        flush;
    logic        e_sig2;
    logic        e_vld;
    ifmp1_word_t e_data;
    int          e_level;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic vld, ifmp1_word_t data, logic rdy, logic flush,
                              logic e_sig2, logic e_vld, ifmp1_word_t e_data,
                              int e_level, logic e_busy);
    vec_t v;
    v.vld = vld; v.data = data; v.rdy = rdy; v.flush = flush;
    v.e_sig2 = e_sig2; v.e_vld = e_vld; v.e_data = e_data;
    v.e_level = e_level; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive inputs, cross one rising edge, then settle 1 time unit before sampling.
  task automatic cycle(input logic vld, input ifmp1_word_t data, input logic rdy,
                       input logic flush);
    bus.sig1_vld = vld;
    bus.sig1     = data;
    bus.out_rdy  = rdy;
    bus.flush    = flush;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bus.sig1_vld = 1'b0;
    bus.sig1     = '0;
    bus.out_rdy  = 1'b0;
    bus.flush    = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Reference model: accepted words in arrival order plus the visible head.
  ifmp1_word_t      m_q[$];
  logic             m_sig2;
  logic             m_vld;
  ifmp1_word_t      m_data;
  logic             m_in_flush;

  task automatic model_reset();
    m_q.delete();
    m_sig2     = 1'b1;   // first edge after reset release already happened
    m_vld      = 1'b0;
    m_data     = '0;
    m_in_flush = 1'b0;
  endtask

  task automatic model_step(input logic vld, input ifmp1_word_t data, input logic rdy,
                            input logic flush);
    logic acc;
    logic take;
    acc  = vld && m_sig2;
    take = m_vld && rdy;
    if (flush) begin
      m_q.delete();
      m_vld      = 1'b0;
      m_sig2     = 1'b0;
      m_in_flush = !m_in_flush;
    end else begin
      if (take) void'(m_q.pop_front());
      m_vld = (m_q.size() > 0);
      if (m_vld) m_data = m_q[0];
      if (acc) m_q.push_back(data);
      m_sig2     = (m_q.size() < DEPTH);
      m_in_flush = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".sig2"},     32'(bus.sig2),    32'(m_sig2));
    check({tag, ".out_vld"},  32'(bus.out_vld), 32'(m_vld));
    check({tag, ".out_data"}, bus.out_data,     m_data);
    check({tag, ".level"},    32'(bus.level),   32'(m_q.size()));
    check({tag, ".busy"},     32'(bus.busy),    32'(!m_in_flush && m_q.size() > 0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        vld;
    logic        rdy;
    logic        fl;
    ifmp1_word_t d;
    int          rdy_pct;
    int          accepted;

    // ---------------- reset, including an assertion mid-transfer
    apply_reset();
    check("rst.sig2_after_release", 32'(bus.sig2), 32'd1);
    check("rst.level_after_release", 32'(bus.level), 32'd0);
    cycle(1'b1, 32'hA1, 1'b0, 1'b0);
    cycle(1'b1, 32'hA2, 1'b0, 1'b0);
    cycle(1'b0, 32'h0,  1'b0, 1'b0);
    check("pre_rst.level", 32'(bus.level), 32'd2);
    check("pre_rst.out_vld", 32'(bus.out_vld), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst.sig2",     32'(bus.sig2),    32'd0);
    check("mid_rst.out_vld",  32'(bus.out_vld), 32'd0);
    check("mid_rst.busy",     32'(bus.busy),    32'd0);
    check("mid_rst.level",    32'(bus.level),   32'd0);
    check("mid_rst.out_data", bus.out_data,     32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_rst.sig2_before_edge", 32'(bus.sig2), 32'd0);
    @(posedge clk);
    #1;
    check("rel_rst.sig2_after_edge", 32'(bus.sig2), 32'd1);

    // ---------------- table: vld data rdy flush | sig2 out_vld out_data level busy
    // single word
    vecs.push_back(mk(1, 32'hDEADBEEF, 1, 0,  1, 0, 32'h0,        1, 1));
    vecs.push_back(mk(0, 32'h0,        1, 0,  1, 1, 32'hDEADBEEF, 1, 1));
    vecs.push_back(mk(0, 32'h0,        1, 0,  1, 0, 32'hDEADBEEF, 0, 0));
    // fill with consumer stalled, then drain
    vecs.push_back(mk(1, 32'h1, 0, 0,  1, 0, 32'hDEADBEEF, 1, 1));
    vecs.push_back(mk(1, 32'h2, 0, 0,  1, 1, 32'h1, 2, 1));
    vecs.push_back(mk(1, 32'h3, 0, 0,  1, 1, 32'h1, 3, 1));
    vecs.push_back(mk(1, 32'h4, 0, 0,  0, 1, 32'h1, 4, 1));
    vecs.push_back(mk(1, 32'h5, 0, 0,  0, 1, 32'h1, 4, 1));
    vecs.push_back(mk(1, 32'h5, 1, 0,  1, 1, 32'h2, 3, 1));
    vecs.push_back(mk(1, 32'h5, 1, 0,  1, 1, 32'h3, 3, 1));
    vecs.push_back(mk(0, 32'h0, 1, 0,  1, 1, 32'h4, 2, 1));
    vecs.push_back(mk(0, 32'h0, 1, 0,  1, 1, 32'h5, 1, 1));
    vecs.push_back(mk(0, 32'h0, 1, 0,  1, 0, 32'h5, 0, 0));
    // simultaneous push and pop at level 2
    vecs.push_back(mk(1, 32'h10, 0, 0,  1, 0, 32'h5,  1, 1));
    vecs.push_back(mk(1, 32'h11, 0, 0,  1, 1, 32'h10, 2, 1));
    vecs.push_back(mk(1, 32'h12, 1, 0,  1, 1, 32'h11, 2, 1));
    vecs.push_back(mk(1, 32'h13, 1, 0,  1, 1, 32'h12, 2, 1));
    vecs.push_back(mk(0, 32'h0,  0, 0,  1, 1, 32'h12, 2, 1));
    // full with a pop: ready stays low during that cycle
    vecs.push_back(mk(1, 32'h14, 0, 0,  1, 1, 32'h12, 3, 1));
    vecs.push_back(mk(1, 32'h15, 0, 0,  0, 1, 32'h12, 4, 1));
    vecs.push_back(mk(1, 32'h16, 1, 0,  1, 1, 32'h13, 3, 1));
    // flush at level 3 with a word offered
    vecs.push_back(mk(1, 32'h77, 0, 1,  0, 0, 32'h13, 0, 0));
    vecs.push_back(mk(1, 32'h78, 0, 0,  1, 0, 32'h13, 0, 0));
    vecs.push_back(mk(1, 32'h78, 0, 0,  1, 0, 32'h13, 1, 1));
    vecs.push_back(mk(0, 32'h0,  1, 0,  1, 1, 32'h78, 1, 1));
    vecs.push_back(mk(0, 32'h0,  1, 0,  1, 0, 32'h78, 0, 0));

    foreach (vecs[i]) begin
      cycle(vecs[i].vld, vecs[i].data, vecs[i].rdy, vecs[i].flush);
      check($sformatf("vec%0d.sig2", i),     32'(bus.sig2),    32'(vecs[i].e_sig2));
      check($sformatf("vec%0d.out_vld", i),  32'(bus.out_vld), 32'(vecs[i].e_vld));
      check($sformatf("vec%0d.out_data", i), bus.out_data,     vecs[i].e_data);
      check($sformatf("vec%0d.level", i),    32'(bus.level),   32'(vecs[i].e_level));
      check($sformatf("vec%0d.busy", i),     32'(bus.busy),    32'(vecs[i].e_busy));
    end

    // ---------------- random traffic against the reference model
    apply_reset();
    model_reset();
    rdy_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) rdy_pct = $urandom_range(10, 95);
      vld = ($urandom_range(0, 3) != 0);
      d   = $urandom;
      rdy = ($urandom_range(1, 100) <= rdy_pct);
      fl  = ($urandom_range(0, 39) == 0);
      model_step(vld, d, rdy, fl);
      cycle(vld, d, rdy, fl);
      check_model($sformatf("rnd%0d", c));
    end

`ifdef IFMP1_RSP_STATS_EN
    // ---------------- accepted-word counter
    apply_reset();
    check("stats.reset", accept_cnt, 32'd0);
    accepted = 0;
    for (int c = 0; c < 60 && accepted < 7; c++) begin
      if (bus.sig2) accepted++;
      cycle(1'b1, 32'(c), 1'b1, 1'b0);
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    accepted = 0;
    for (int c = 0; c < 60 && accepted < 2; c++) begin
      if (bus.sig2) accepted++;
      cycle(1'b1, 32'(c), 1'b1, 1'b0);
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("stats.count_7_flush_2", accept_cnt, 32'd9);
    force dut.accept_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.accept_cnt_q;
    accepted = 0;
    for (int c = 0; c < 60 && accepted < 1; c++) begin
      if (bus.sig2) accepted++;
      cycle(1'b1, 32'h99, 1'b1, 1'b0);
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("stats.wrap", accept_cnt, 32'd0);
`else
    accepted = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
